ctrl_fsm_ws: RTL and testbench
==============================

# ctrl_fsm_ws

Parametrised multi-cycle controller for the RISC datapath. It sequences instruction fetch, decode and execute, and drives the datapath, program-counter and memory-interface control lines. It extends the single-cycle-memory controller with three additions: configurable memory wait states, a non-executing fallback path for undefined encodings, and an optional halt state. It sits between the instruction register decoder and the datapath/RAM.

## Interface
- `MEM_WAIT`, default 0: extra cycles each memory access state is held; legal range 0..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; forces state RST immediately.
- `opcode` input 3: decoded IR[15:13].
- `op` input 2: decoded IR[12:11].
- `nsel` output 3: one-hot register select. Rn=001, Rd=010, Rm=100, none=000.
- `vsel` output 2: writeback source. 00=C, 01=mdata, 10=sximm8.
- `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`, `write` output 1 each: datapath controls.
- `load_pc`, `reset_pc`, `addr_sel`, `load_ir`, `load_addr` output 1 each: PC, address and IR controls.
- `mem_cmd` output 2: 00=MNONE, 01=MREAD, 10=MWRITE.
- `w` output 1: high only in HALT.

## Operation
- Moore machine: outputs are a function of the registered state only.
- Every output not listed for a state is 0; `nsel`=000; `mem_cmd`=MNONE.

State outputs and transitions:
- RST: `reset_pc`=1, `load_pc`=1. Goes to IF1.
- IF1: `addr_sel`=1, MREAD. Held MEM_WAIT+1 cycles, then IF2.
- IF2: `addr_sel`=1, MREAD, `load_ir`=1. Goes to UPDATEPC.
- UPDATEPC: `load_pc`=1. Goes to DECODE.

DECODE branches on {opcode,op}:
- 110_10 → WRITEIMM.
- 110_00 → GETB.
- 101_xx → GETB.
- 011_00 → GETA.
- 100_00 → GETA.
- 111_xx → HALT (see Configuration).
- Any other encoding → IF1 as a NOP. No write, no memory command.

Execute states:
- WRITEIMM: `nsel`=Rn, `vsel`=10, `write`=1. Goes to IF1.
- GETB: `nsel`=Rm, `loadb`=1.
  - MOV reg → MOVSH.
  - MVN (101_11) → ALU.
  - Other 101 ops → GETA.
- GETA: `nsel`=Rn, `loada`=1.
  - 101 ops → ALU.
  - LDR/STR → ADDR.
- MOVSH: `asel`=1, `loadc`=1. Goes to WRITEREG.
- ALU:
  - CMP (101_01): `loads`=1 only, then IF1.
  - ADD/AND/MVN: `loadc`=1, then WRITEREG.
- WRITEREG: `nsel`=Rd, `vsel`=00, `write`=1. Goes to IF1.

Memory states:
- ADDR: `bsel`=1, `loadc`=1. Goes to LDADDR.
- LDADDR: `load_addr`=1.
  - LDR → MEMRD.
  - STR → GETRD.
- MEMRD: MREAD, `addr_sel`=0. Held MEM_WAIT+1 cycles, then WRMEM.
- WRMEM: MREAD, `nsel`=Rd, `vsel`=01, `write`=1. Goes to IF1.
- GETRD: `nsel`=Rd, `loadb`=1. Goes to OUTRD.
- OUTRD: `asel`=1, `loadc`=1. Goes to MEMWR.
- MEMWR: MWRITE. Held MEM_WAIT+1 cycles, then IF1.

Other rules:
- HALT: `w`=1. Remains in HALT until `reset` is asserted.
- Wait counter is 4 bits wide.
  - Loaded with MEM_WAIT on the edge that enters IF1, MEMRD or MEMWR.
  - Decrements each cycle while in that state.
  - The state is left on the edge where the counter equals 0.
- `opcode`/`op` are sampled only in DECODE, GETB, GETA, ALU and LDADDR. Changes at other times are ignored.

## Timing
- `reset` low: state=RST and counter=0 immediately, with no clock required. RST outputs hold while `reset` is low.
- First rising edge after `reset` goes high enters IF1.
- With MEM_WAIT=0, from reset release:
  - IF1, IF2, UPDATEPC, DECODE occupy edges 1-4.
  - Fetch overhead is 4 cycles; each fetch adds MEM_WAIT cycles.
- Instruction latency from DECODE to IF1 (MEM_WAIT=0):
  - MOV imm: 2.
  - MOV reg: 4.
  - ADD/AND: 5.
  - MVN: 4.
  - CMP: 4.
  - LDR: 6+MEM_WAIT.
  - STR: 7+MEM_WAIT.
- Reset asserted mid-instruction, in any state including a wait hold:
  - Aborts at once to RST.
  - No further `write` or `mem_cmd` pulse is issued.

## Configuration
- `CTRL_HALT_EN` defined: 111_xx enters HALT.
- `CTRL_HALT_EN` undefined:
  - HALT state is not compiled.
  - 111_xx follows the undefined-encoding NOP path (DECODE → IF1).
  - `w` is tied to 0.

## Test plan
- Reset release, MEM_WAIT=0 → states RST, IF1, IF2, UPDATEPC, DECODE on consecutive edges. `reset_pc`=1 in RST only.
- MEM_WAIT=3, fetch:
  - IF1 lasts 4 cycles with `mem_cmd`=01 and `addr_sel`=1.
  - `load_ir`=1 for exactly 1 cycle.
- DECODE with opcode=101, op=00 → GETB, GETA, ALU, WRITEREG. WRITEREG drives `nsel`=010 and `write`=1 for one cycle.
- LDR with MEM_WAIT=2:
  - MEMRD lasts 3 cycles.
  - WRMEM drives `vsel`=01, `write`=1.
- STR: MEMWR drives `mem_cmd`=10 for MEM_WAIT+1 cycles, then IF1.
- Edge cases:
  - opcode=111 with `CTRL_HALT_EN` → `w`=1 indefinitely; without it → IF1.
  - `reset` pulled low during MEMWR → RST within the same cycle, `mem_cmd`=00.

Source files
------------

// File: rtl/ctrl_fsm_ws_if.sv
// ctrl_fsm_ws_if: bundle between the instruction decoder/datapath and the controller.
//   opcode[2:0], op[1:0]        decoded IR[15:13] / IR[12:11] (datapath -> controller)
//   nsel[2:0], vsel[1:0]        register select (one-hot Rn/Rd/Rm) and writeback source
//   loada..write                datapath register loads, operand muxes, register-file write
//   load_pc, reset_pc, addr_sel PC and memory-address controls
//   load_ir, load_addr          instruction/data-address register loads
//   mem_cmd[1:0]                00 none, 01 read, 10 write
//   w                           high while halted
//   modport master: controller side; modport slave: datapath/memory side
interface ctrl_fsm_ws_if;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic       load_pc, reset_pc, addr_sel, load_ir, load_addr;
    logic [1:0] mem_cmd;
    logic       w;
    modport master (
        input  opcode, op,
        output nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
               load_pc, reset_pc, addr_sel, load_ir, load_addr, mem_cmd, w
    );
    modport slave (
        output opcode, op,
        input  nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
               load_pc, reset_pc, addr_sel, load_ir, load_addr, mem_cmd, w
    );
endinterface

// File: rtl/ctrl_fsm_ws.sv
// ctrl_fsm_ws: multi-cycle fetch/decode/execute controller with memory wait states.
//   MEM_WAIT    extra cycles every memory-access state is held (0..15)
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, forces RST
//   bus         ctrl_fsm_ws_if.master: opcode/op in, all datapath/PC/memory controls out
//   CTRL_HALT_EN  when defined, opcode 111 enters a HALT state (w=1) until reset;
//                 otherwise 111 is treated as an undefined encoding (NOP) and w is 0.
module ctrl_fsm_ws #(
    parameter int MEM_WAIT = 0
) (
    input logic           clk,
    input logic           reset,
    ctrl_fsm_ws_if.master bus
);
    // CMP gets its own ALU state so that loads/loadc stay a pure function of state.
    typedef enum logic [4:0] {
        RST, IF1, IF2, UPDATEPC, DECODE, WRITEIMM, GETB, GETA, MOVSH, ALU, ALU_CMP,
        WRITEREG, ADDR, LDADDR, MEMRD, WRMEM, GETRD, OUTRD, MEMWR
`ifdef CTRL_HALT_EN
        , HALT
`endif
    } state_t;

    state_t     st, nxt;
    logic [3:0] cnt;
    logic       done;

    assign done = cnt == 4'd0;

    // The wait counter is reloaded on every edge that enters a memory state and
    // counts down to 0 while there; it is only nonzero inside such a state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= RST;
            cnt <= 4'd0;
        end else begin
            st  <= nxt;
            cnt <= (nxt != st && (nxt == IF1 || nxt == MEMRD || nxt == MEMWR)) ? 4'(MEM_WAIT)
                 : done ? cnt : cnt - 4'd1;
        end
    end

    always_comb begin
        nxt = st;
        case (st)
            RST:      nxt = IF1;
            IF1:      nxt = done ? IF2 : IF1;
            IF2:      nxt = UPDATEPC;
            UPDATEPC: nxt = DECODE;
            DECODE: begin
                casez ({bus.opcode, bus.op})
                    5'b110_10:           nxt = WRITEIMM;
                    5'b110_00, 5'b101_??: nxt = GETB;
                    5'b011_00, 5'b100_00: nxt = GETA;
`ifdef CTRL_HALT_EN
                    5'b111_??:           nxt = HALT;
`endif
                    default:             nxt = IF1;
                endcase
            end
            WRITEIMM: nxt = IF1;
            GETB:     nxt = bus.opcode != 3'b101 ? MOVSH : bus.op == 2'b11 ? ALU : GETA;
            GETA:     nxt = bus.opcode != 3'b101 ? ADDR : bus.op == 2'b01 ? ALU_CMP : ALU;
            MOVSH:    nxt = WRITEREG;
            ALU:      nxt = WRITEREG;
            ALU_CMP:  nxt = IF1;
            WRITEREG: nxt = IF1;
            ADDR:     nxt = LDADDR;
            LDADDR:   nxt = bus.opcode == 3'b011 ? MEMRD : GETRD;
            MEMRD:    nxt = done ? WRMEM : MEMRD;
            WRMEM:    nxt = IF1;
            GETRD:    nxt = OUTRD;
            OUTRD:    nxt = MEMWR;
            MEMWR:    nxt = done ? IF1 : MEMWR;
`ifdef CTRL_HALT_EN
            HALT:     nxt = HALT;
`endif
            default:  nxt = RST;
        endcase
    end

    assign bus.nsel      = (st == WRITEIMM || st == GETA) ? 3'b001
                         : st == GETB ? 3'b100
                         : (st == WRITEREG || st == WRMEM || st == GETRD) ? 3'b010 : 3'b000;
    assign bus.vsel      = st == WRITEIMM ? 2'b10 : st == WRMEM ? 2'b01 : 2'b00;
    assign bus.loada     = st == GETA;
    assign bus.loadb     = st == GETB || st == GETRD;
    assign bus.loadc     = st == MOVSH || st == ALU || st == ADDR || st == OUTRD;
    assign bus.loads     = st == ALU_CMP;
    assign bus.asel      = st == MOVSH || st == OUTRD;
    assign bus.bsel      = st == ADDR;
    assign bus.write     = st == WRITEIMM || st == WRITEREG || st == WRMEM;
    assign bus.load_pc   = st == RST || st == UPDATEPC;
    assign bus.reset_pc  = st == RST;
    assign bus.addr_sel  = st == IF1 || st == IF2;
    assign bus.load_ir   = st == IF2;
    assign bus.load_addr = st == LDADDR;
    assign bus.mem_cmd   = (st == IF1 || st == IF2 || st == MEMRD || st == WRMEM) ? 2'b01
                         : st == MEMWR ? 2'b10 : 2'b00;
`ifdef CTRL_HALT_EN
    assign bus.w         = st == HALT;
`else
    assign bus.w         = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_fsm_ws.sv
// tb_ctrl_fsm_ws: two controllers (MEM_WAIT 0 and 3) run the same random program; each
// cycle's control word is compared with a per-instruction output trace built from the
// instruction timing table.
module tb_ctrl_fsm_ws;
    typedef logic [19:0] ov_t;  // {nsel, vsel, 12 flags, mem_cmd, w}

    localparam logic [11:0] F_LOADA = 12'h800, F_LOADB = 12'h400, F_LOADC = 12'h200,
        F_LOADS = 12'h100, F_ASEL = 12'h080, F_BSEL = 12'h040, F_WRITE = 12'h020,
        F_LOAD_PC = 12'h010, F_RESET_PC = 12'h008, F_ADDR_SEL = 12'h004,
        F_LOAD_IR = 12'h002, F_LOAD_ADDR = 12'h001;
    localparam logic [2:0] RN = 3'b001, RD = 3'b010, RM = 3'b100;
    localparam logic [1:0] MRD = 2'b01, MWR = 2'b10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0, total = 0;

    ctrl_fsm_ws_if b0 ();
    ctrl_fsm_ws_if b1 ();
    ctrl_fsm_ws #(.MEM_WAIT(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    ctrl_fsm_ws #(.MEM_WAIT(3)) u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    ov_t g0, g1;
    assign g0 = {b0.nsel, b0.vsel, b0.loada, b0.loadb, b0.loadc, b0.loads, b0.asel, b0.bsel,
                 b0.write, b0.load_pc, b0.reset_pc, b0.addr_sel, b0.load_ir, b0.load_addr,
                 b0.mem_cmd, b0.w};
    assign g1 = {b1.nsel, b1.vsel, b1.loada, b1.loadb, b1.loadc, b1.loads, b1.asel, b1.bsel,
                 b1.write, b1.load_pc, b1.reset_pc, b1.addr_sel, b1.load_ir, b1.load_addr,
                 b1.mem_cmd, b1.w};

    function automatic ov_t mk(logic [2:0] n, logic [1:0] v, logic [11:0] f, logic [1:0] m,
                               logic ww);
        return {n, v, f, m, ww};
    endfunction

    ov_t        rstv;
    ov_t        ex[2][2048];
    logic [4:0] ix[2][2048];
    int         len[2];
    int         mwi[2];
    logic [4:0] prog[64];
    int         nprog;

    task automatic chk(string tag, ov_t got, ov_t exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic push(int d, ov_t v, logic [4:0] x);
        ex[d][len[d]] = v;
        ix[d][len[d]] = x;
        len[d]++;
    endtask

    // Fetch: IF1 for mw+1 cycles, IF2, UPDATEPC; inputs are don't-care, so feed noise.
    task automatic fetch(int d, int mw);
        for (int i = 0; i <= mw; i++) push(d, mk(0, 0, F_ADDR_SEL, MRD, 0), 5'($urandom));
        push(d, mk(0, 0, F_ADDR_SEL | F_LOAD_IR, MRD, 0), 5'($urandom));
        push(d, mk(0, 0, F_LOAD_PC, 0, 0), 5'($urandom));
    endtask

    task automatic build(int d, int mw);
        logic [4:0] x;
        bit halted;
        halted = 0;
        len[d] = 0;
        mwi[d] = -1;
        for (int k = 0; k < nprog && !halted; k++) begin
            x = prog[k];
            fetch(d, mw);
            push(d, 20'd0, x);
            if (x == 5'b11010) push(d, mk(RN, 2'b10, F_WRITE, 0, 0), x);
            else if (x == 5'b11000) begin
                push(d, mk(RM, 0, F_LOADB, 0, 0), x);
                push(d, mk(0, 0, F_ASEL | F_LOADC, 0, 0), x);
                push(d, mk(RD, 0, F_WRITE, 0, 0), x);
            end else if (x[4:2] == 3'b101) begin
                push(d, mk(RM, 0, F_LOADB, 0, 0), x);
                if (x[1:0] != 2'b11) push(d, mk(RN, 0, F_LOADA, 0, 0), x);
                if (x[1:0] == 2'b01) push(d, mk(0, 0, F_LOADS, 0, 0), x);
                else begin
                    push(d, mk(0, 0, F_LOADC, 0, 0), x);
                    push(d, mk(RD, 0, F_WRITE, 0, 0), x);
                end
            end else if (x == 5'b01100 || x == 5'b10000) begin
                push(d, mk(RN, 0, F_LOADA, 0, 0), x);
                push(d, mk(0, 0, F_BSEL | F_LOADC, 0, 0), x);
                push(d, mk(0, 0, F_LOAD_ADDR, 0, 0), x);
                if (x == 5'b01100) begin
                    for (int i = 0; i <= mw; i++) push(d, mk(0, 0, 0, MRD, 0), x);
                    push(d, mk(RD, 2'b01, F_WRITE, MRD, 0), x);
                end else begin
                    push(d, mk(RD, 0, F_LOADB, 0, 0), x);
                    push(d, mk(0, 0, F_ASEL | F_LOADC, 0, 0), x);
                    mwi[d] = len[d];
                    for (int i = 0; i <= mw; i++) push(d, mk(0, 0, 0, MWR, 0), x);
                end
            end
`ifdef CTRL_HALT_EN
            else if (x[4:2] == 3'b111) begin
                for (int i = 0; i < 8; i++) push(d, mk(0, 0, 0, 0, 1), 5'($urandom));
                halted = 1;
            end
`endif
        end
        if (!halted) fetch(d, mw);
    endtask

    function automatic bit known(logic [4:0] x);
        return x == 5'b11010 || x == 5'b11000 || x == 5'b01100 || x == 5'b10000 ||
               x[4:2] == 3'b101 || x[4:2] == 3'b111;
    endfunction

    function automatic logic [4:0] rand_instr();
        logic [4:0] x;
        case ($urandom_range(0, 8))
            0: x = 5'b11010;
            1: x = 5'b11000;
            2: x = 5'b10100;
            3: x = 5'b10101;
            4: x = 5'b10110;
            5: x = 5'b10111;
            6: x = 5'b01100;
            7: x = 5'b10000;
            default: begin
                x = 5'($urandom);
                while (known(x)) x = 5'($urandom);
            end
        endcase
        return x;
    endfunction

    // Run the current program from a reset release; optionally pull reset in the
    // second MEMWR cycle of the MEM_WAIT=3 controller.
    task automatic run(bit abort);
        int n, ab;
        build(0, 0);
        build(1, 3);
        ab = abort ? mwi[1] + 1 : -1;
        reset = 1'b0;
        @(negedge clk);
        chk("hold0", g0, rstv);
        chk("hold1", g1, rstv);
        reset = 1'b1;
        n = len[0] > len[1] ? len[0] : len[1];
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            {b0.opcode, b0.op} = c < len[0] ? ix[0][c] : 5'($urandom);
            {b1.opcode, b1.op} = c < len[1] ? ix[1][c] : 5'($urandom);
            if (c < len[0]) chk($sformatf("mw0_c%0d", c), g0, ex[0][c]);
            if (c < len[1]) chk($sformatf("mw3_c%0d", c), g1, ex[1][c]);
            if (c == ab) begin
                #2 reset = 1'b0;
                #1 chk("abort_mw0", g0, rstv);
                chk("abort_mw3", g1, rstv);
                @(negedge clk);
                chk("abort_hold_mw3", g1, rstv);
                return;
            end
        end
    endtask

    initial begin
        rstv = mk(0, 0, F_RESET_PC | F_LOAD_PC, 0, 0);
        {b0.opcode, b0.op} = 5'd0;
        {b1.opcode, b1.op} = 5'd0;
        #1 reset = 1'b0;
        #1 chk("async_rst0", g0, rstv);
        chk("async_rst1", g1, rstv);
        nprog = 40;
        for (int k = 0; k < nprog; k++) prog[k] = rand_instr();
        run(0);
        nprog = 1;
        prog[0] = 5'b10000;
        run(1);
        nprog = 2;
        prog[0] = {3'b111, 2'($urandom)};
        prog[1] = 5'b10100;
        run(0);
        nprog = 3;
        prog[0] = 5'b01100;
        prog[1] = 5'b10101;
        prog[2] = 5'b11010;
        run(0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
